stream_fifo: RTL

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo.sv | 81 ++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO carrying a signed payload plus a packet-last flag,
// with synchronous flush, occupancy count and an almost-full indication.
module stream_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                               clk,
  input  logic                               rst_async_n,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic signed [DATA_WIDTH-1:0]       s_data,
  input  logic                               s_last,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic signed [DATA_WIDTH-1:0]       m_data,
  output logic                               m_last,
  input  logic                               flush,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic                               almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wrPtr;
  logic [PW-1:0]       r_rdPtr;
  logic [CW-1:0]       r_count;

  logic                w_push;
  logic                w_pop;
  logic [DATA_WIDTH:0] w_head;

  // Handshake flags come only from the registered count, so there is no
  // combinational path from either valid or ready into the other side.
  assign s_ready     = (r_count != CW'(DEPTH));
  assign m_valid     = (r_count != '0);
  assign almost_full = (r_count >= CW'(AFULL_THRESH));
  assign count       = r_count;

  assign w_push = s_valid && s_ready;
  assign w_pop  = m_valid && m_ready;

  assign w_head = r_mem[r_rdPtr];
  assign m_data = $signed(w_head[DATA_WIDTH-1:0]);
  assign m_last = w_head[DATA_WIDTH];

  // Storage is not reset; its contents only matter where count says so.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wrPtr] <= {s_last, s_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
